// File: rtl/sseg_pkg.sv
// sseg_pkg: shared definitions for the seven-segment encoder/decoder pair.
//   - SEG_HEX_0..SEG_HEX_F : active-low cathode patterns (bit0=a .. bit6=g)
//   - SEG_BLANK            : all segments off
//   - seg_bit_e            : cathode bit order
//   - is_onehot_low / onehot_low_index : anode helpers
package sseg_pkg;

  typedef enum logic [2:0] {
    SEG_A = 3'd0,
    SEG_B = 3'd1,
    SEG_C = 3'd2,
    SEG_D = 3'd3,
    SEG_E = 3'd4,
    SEG_F = 3'd5,
    SEG_G = 3'd6
  } seg_bit_e;

  localparam logic [6:0] SEG_HEX_0 = 7'h40;
  localparam logic [6:0] SEG_HEX_1 = 7'h79;
  localparam logic [6:0] SEG_HEX_2 = 7'h24;
  localparam logic [6:0] SEG_HEX_3 = 7'h30;
  localparam logic [6:0] SEG_HEX_4 = 7'h19;
  localparam logic [6:0] SEG_HEX_5 = 7'h12;
  localparam logic [6:0] SEG_HEX_6 = 7'h02;
  localparam logic [6:0] SEG_HEX_7 = 7'h78;
  localparam logic [6:0] SEG_HEX_8 = 7'h00;
  localparam logic [6:0] SEG_HEX_9 = 7'h10;
  localparam logic [6:0] SEG_HEX_A = 7'h08;
  localparam logic [6:0] SEG_HEX_B = 7'h03;
  localparam logic [6:0] SEG_HEX_C = 7'h46;
  localparam logic [6:0] SEG_HEX_D = 7'h21;
  localparam logic [6:0] SEG_HEX_E = 7'h06;
  localparam logic [6:0] SEG_HEX_F = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Exactly one anode driven low selects a single digit.
  function automatic logic is_onehot_low(input logic [3:0] an);
    logic res;
    case (an)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: res = 1'b1;
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

  // Digit number selected by a one-hot-low anode vector (0 otherwise).
  function automatic logic [1:0] onehot_low_index(input logic [3:0] an);
    logic [1:0] idx;
    case (an)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/sseg_seg_decode.sv
// sseg_seg_decode: combinational glyph lookup.
//   ca    : active-low cathodes (bit0=a .. bit6=g)
//   legal : ca is one of the 16 hex glyphs
//   blank : ca is all-off
//   value : hex value of the glyph (0 when not legal)
module sseg_seg_decode
  import sseg_pkg::*;
(
  input  logic [6:0] ca,
  output logic       legal,
  output logic       blank,
  output logic [3:0] value
);

  // Map each cathode pattern to its hex value; anything else is illegal.
  always_comb begin
    legal = 1'b1;
    blank = 1'b0;
    value = 4'h0;
    case (ca)
      SEG_HEX_0: value = 4'h0;
      SEG_HEX_1: value = 4'h1;
      SEG_HEX_2: value = 4'h2;
      SEG_HEX_3: value = 4'h3;
      SEG_HEX_4: value = 4'h4;
      SEG_HEX_5: value = 4'h5;
      SEG_HEX_6: value = 4'h6;
      SEG_HEX_7: value = 4'h7;
      SEG_HEX_8: value = 4'h8;
      SEG_HEX_9: value = 4'h9;
      SEG_HEX_A: value = 4'hA;
      SEG_HEX_B: value = 4'hB;
      SEG_HEX_C: value = 4'hC;
      SEG_HEX_D: value = 4'hD;
      SEG_HEX_E: value = 4'hE;
      SEG_HEX_F: value = 4'hF;
      SEG_BLANK: begin
        legal = 1'b0;
        blank = 1'b1;
      end
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/sseg_decoder.sv
// sseg_decoder: recovers the hex values shown on a multiplexed 4-digit
// seven-segment bus.
//   clk, rst          : clock, synchronous active-high reset
//   sseg_an[3:0]      : active-low anodes, bit N selects digit N
//   sseg_ca[6:0]      : active-low cathodes, bit0=a .. bit6=g
//   digit0..digit3    : last committed value per digit
//   digit_valid[3:0]  : digit last showed a legal hex glyph
//   pattern_err[3:0]  : digit last showed an illegal non-blank pattern
//   frame_done        : one-cycle pulse once all 4 digits were committed
//   scan_active       : commits are still arriving within TIMEOUT_CYCLES
module sseg_decoder
  import sseg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sseg_an,
  input  logic [6:0] sseg_ca,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit_valid,
  output logic [3:0] pattern_err,
  output logic       frame_done,
  output logic       scan_active
);

  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES);

  logic [3:0]        an_r;
  logic [6:0]        ca_r;
  logic [STAB_W-1:0] stab_cnt_r;
  logic [IDLE_W-1:0] idle_cnt_r;
  logic [3:0]        seen_r;
  logic [3:0]        digit_r [4];
  logic [3:0]        digit_valid_r;
  logic [3:0]        pattern_err_r;
  logic              frame_done_r;
  logic              scan_active_r;

  logic              commit_s;
  logic              timeout_s;
  logic [1:0]        idx_s;
  logic [3:0]        seen_next_s;
  logic              dec_legal_s;
  logic              dec_blank_s;
  logic [3:0]        dec_value_s;

  sseg_seg_decode u_seg_decode (
    .ca    (ca_r),
    .legal (dec_legal_s),
    .blank (dec_blank_s),
    .value (dec_value_s)
  );

  // Input register and stability counter. The counter holds the number of
  // repeats of the registered pair, so it reads STABLE_CYCLES-1 exactly when
  // STABLE_CYCLES identical samples sit in the input register's history.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_r       <= 4'h0;
      ca_r       <= 7'h00;
      stab_cnt_r <= '0;
    end else begin
      an_r <= sseg_an;
      ca_r <= sseg_ca;
      if ({sseg_an, sseg_ca} == {an_r, ca_r}) begin
        if (stab_cnt_r != STAB_MAX) begin
          stab_cnt_r <= stab_cnt_r + STAB_W'(1);
        end
      end else begin
        stab_cnt_r <= '0;
      end
    end
  end

  // Commit / timeout decisions. The counter passes STAB_LAST only once per
  // stable period, which limits commits to one per period.
  always_comb begin
    commit_s    = 1'b0;
    timeout_s   = 1'b0;
    idx_s       = onehot_low_index(an_r);
    seen_next_s = seen_r | ~an_r;
    if ((stab_cnt_r == STAB_LAST) && is_onehot_low(an_r)) begin
      commit_s = 1'b1;
    end else if (idle_cnt_r == IDLE_LAST) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Output state: digit values, flags, frame tracking and idle timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        digit_r[i] <= 4'h0;
      end
      digit_valid_r <= 4'h0;
      pattern_err_r <= 4'h0;
      frame_done_r  <= 1'b0;
      scan_active_r <= 1'b0;
      seen_r        <= 4'h0;
      idle_cnt_r    <= '0;
    end else begin
      frame_done_r <= 1'b0;
      if (commit_s) begin
        scan_active_r <= 1'b1;
        idle_cnt_r    <= '0;
        if (dec_legal_s) begin
          digit_r[idx_s] <= dec_value_s;
        end
        digit_valid_r[idx_s] <= dec_legal_s;
        pattern_err_r[idx_s] <= ~dec_legal_s & ~dec_blank_s;
        if (seen_next_s == 4'hF) begin
          frame_done_r <= 1'b1;
          seen_r       <= 4'h0;
        end else begin
          seen_r <= seen_next_s;
        end
      end else if (timeout_s) begin
        scan_active_r <= 1'b0;
        digit_valid_r <= 4'h0;
        seen_r        <= 4'h0;
        idle_cnt_r    <= IDLE_MAX;
      end else if (idle_cnt_r != IDLE_MAX) begin
        idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
      end
    end
  end

  assign digit0      = digit_r[0];
  assign digit1      = digit_r[1];
  assign digit2      = digit_r[2];
  assign digit3      = digit_r[3];
  assign digit_valid = digit_valid_r;
  assign pattern_err = pattern_err_r;
  assign frame_done  = frame_done_r;
  assign scan_active = scan_active_r;

endmodule

// File: tb/tb_sseg_decoder.sv
// tb_sseg_decoder: directed and random stimulus for sseg_decoder, checked
// every cycle against a behavioural model based on sample history.
module tb_sseg_decoder;

  localparam int S = 4;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sseg_an;
  logic [6:0] sseg_ca;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [3:0] digit_valid, pattern_err;
  logic       frame_done, scan_active;

  sseg_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .sseg_an     (sseg_an),
    .sseg_ca     (sseg_ca),
    .digit0      (digit0),
    .digit1      (digit1),
    .digit2      (digit2),
    .digit3      (digit3),
    .digit_valid (digit_valid),
    .pattern_err (pattern_err),
    .frame_done  (frame_done),
    .scan_active (scan_active)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int fd_count     = 0;

  logic [6:0] glyphs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // reference model state
  logic [3:0]  m_digit [4];
  logic [3:0]  m_valid, m_perr, m_seen;
  logic        m_fd, m_scan;
  int          m_idle;
  logic [10:0] hist [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int glyph_index(input logic [6:0] ca);
    for (int i = 0; i < 16; i++) begin
      if (glyphs[i] == ca) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] pack_dut();
    return {6'd0, digit3, digit2, digit1, digit0, digit_valid, pattern_err, frame_done, scan_active};
  endfunction

  function automatic logic [31:0] pack_model();
    return {6'd0, m_digit[3], m_digit[2], m_digit[1], m_digit[0], m_valid, m_perr, m_fd, m_scan};
  endfunction

  // One clock edge of the model. A digit is committed when the S samples
  // before this edge are identical, the sample before them differs, and
  // exactly one anode is low.
  task automatic model_edge(input logic [3:0] an, input logic [6:0] ca, input logic r);
    logic        commit;
    logic [10:0] last;
    int          n, zeros, gi;
    if (r) begin
      for (int i = 0; i < 4; i++) m_digit[i] = 4'h0;
      m_valid = 4'h0; m_perr = 4'h0; m_seen = 4'h0;
      m_fd = 1'b0; m_scan = 1'b0; m_idle = 0;
      hist.delete();
      hist.push_back(11'h000);
      return;
    end
    m_fd   = 1'b0;
    commit = 1'b0;
    n      = 0;
    if (hist.size() >= S + 1) begin
      last   = hist[hist.size() - 1];
      commit = (hist[hist.size() - 1 - S] != last);
      for (int k = 2; k <= S; k++) begin
        if (hist[hist.size() - k] != last) commit = 1'b0;
      end
      zeros = 0;
      for (int b = 0; b < 4; b++) begin
        if (!last[7 + b]) begin
          zeros++;
          n = b;
        end
      end
      if (zeros != 1) commit = 1'b0;
      if (commit) begin
        gi = glyph_index(last[6:0]);
        if (gi >= 0) begin
          m_digit[n] = gi[3:0];
          m_valid[n] = 1'b1;
          m_perr[n]  = 1'b0;
        end else begin
          m_valid[n] = 1'b0;
          m_perr[n]  = (last[6:0] != 7'h7F);
        end
        m_seen[n] = 1'b1;
        if (m_seen == 4'hF) begin
          m_fd   = 1'b1;
          m_seen = 4'h0;
        end
        m_scan = 1'b1;
        m_idle = 0;
      end
    end
    if (!commit) begin
      m_idle++;
      if (m_idle == T) begin
        m_scan  = 1'b0;
        m_valid = 4'h0;
        m_seen  = 4'h0;
      end
    end
    hist.push_back({an, ca});
    while (hist.size() > S + 1) void'(hist.pop_front());
  endtask

  task automatic step(input logic [3:0] an, input logic [6:0] ca, input logic r);
    sseg_an = an;
    sseg_ca = ca;
    rst     = r;
    @(posedge clk);
    #1;
    model_edge(an, ca, r);
    if (frame_done === 1'b1) fd_count++;
    check_eq("cycle_outputs", pack_dut(), pack_model());
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] ca, input int n);
    for (int i = 0; i < n; i++) step(an, ca, 1'b0);
  endtask

  initial begin
    logic [3:0] ran;
    logic [6:0] rca;
    int         len;
    sseg_an = 4'hF;
    sseg_ca = 7'h7F;
    rst     = 1'b1;
    #2;
    step(4'hF, 7'h7F, 1'b1);
    step(4'hF, 7'h7F, 1'b1);
    check_eq("reset_state", pack_dut(), 32'h0);

    // short hold never commits; S samples commit on the following edge
    hold(4'b1110, 7'h40, 3);
    hold(4'b1101, 7'h79, 2);
    check_eq("short_hold_valid", {28'd0, digit_valid}, 32'h0);
    hold(4'b1110, 7'h40, 4);
    check_eq("latency_early", {31'd0, digit_valid[0]}, 32'h0);
    step(4'hF, 7'h7F, 1'b0);
    check_eq("latency_valid", {31'd0, digit_valid[0]}, 32'h1);
    check_eq("latency_digit0", {28'd0, digit0}, 32'h0);

    // frame with a repeated digit: 0,1,1,2,3
    step(4'hF, 7'h7F, 1'b1);
    fd_count = 0;
    hold(4'b1110, glyphs[0], S + 1);
    hold(4'b1101, glyphs[7], S + 1);
    hold(4'b1101, glyphs[1], S + 1);
    hold(4'b1011, glyphs[2], S + 1);
    check_eq("frame_not_yet", fd_count, 32'd0);
    hold(4'b0111, glyphs[3], S + 1);
    hold(4'hF, 7'h7F, 2);
    check_eq("frame_once", fd_count, 32'd1);
    check_eq("frame_digits", {16'd0, digit3, digit2, digit1, digit0}, 32'h3210);
    check_eq("frame_valid", {28'd0, digit_valid}, 32'hF);
    check_eq("frame_perr", {28'd0, pattern_err}, 32'h0);

    // blank then illegal on digit 2
    hold(4'b1011, 7'h7F, S + 1);
    check_eq("blank_flags", {30'd0, digit_valid[2], pattern_err[2]}, 32'h0);
    hold(4'b1011, 7'h55, S + 1);
    check_eq("illegal_flags", {30'd0, digit_valid[2], pattern_err[2]}, 32'h1);
    check_eq("illegal_hold_digit2", {28'd0, digit2}, 32'h2);

    // idle timeout
    hold(4'hF, 7'h7F, T - 1);
    check_eq("pre_timeout_active", {31'd0, scan_active}, 32'h1);
    step(4'hF, 7'h7F, 1'b0);
    check_eq("timeout_active", {31'd0, scan_active}, 32'h0);
    check_eq("timeout_valid", {28'd0, digit_valid}, 32'h0);
    check_eq("timeout_digits", {16'd0, digit3, digit2, digit1, digit0}, 32'h3210);
    hold(4'b1110, glyphs[9], S + 1);
    check_eq("recommit_active", {31'd0, scan_active}, 32'h1);

    // reset mid-frame discards progress
    hold(4'b1101, glyphs[4], S + 1);
    step(4'hF, 7'h7F, 1'b1);
    check_eq("midframe_reset", pack_dut(), 32'h0);
    fd_count = 0;
    hold(4'b1011, glyphs[5], S + 1);
    hold(4'b0111, glyphs[6], S + 1);
    hold(4'b1110, glyphs[8], S + 1);
    check_eq("post_reset_no_frame", fd_count, 32'd0);
    hold(4'b1101, glyphs[10], S + 1);
    hold(4'hF, 7'h7F, 1);
    check_eq("post_reset_frame", fd_count, 32'd1);

    // random scan traffic
    for (int it = 0; it < 600; it++) begin
      case ($urandom_range(0, 5))
        0, 1, 2, 3: ran = ~(4'b0001 << $urandom_range(0, 3));
        4:          ran = 4'hF;
        default:    ran = 4'($urandom());
      endcase
      case ($urandom_range(0, 15))
        12:      rca = 7'h7F;
        13, 14:  rca = 7'($urandom());
        15:      rca = 7'h55;
        default: rca = glyphs[$urandom_range(0, 15)];
      endcase
      len = (it % 40 == 39) ? T + 2 : $urandom_range(1, 7);
      if ($urandom_range(0, 79) == 0) begin
        step(ran, rca, 1'b1);
      end else begin
        hold(ran, rca, len);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
